// File: rtl/mem_stage.sv
// Memory stage: one d-cache access per load/store, 1-cycle commit when the cache answers at once.
// Backpressure: ctrl_mem_stall while waiting on the cache; results that finish under ctrl_stall park in a hold buffer.
module mem_stage #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst_n,
  input  logic        ctrl_stall,
  input  logic        in_valid,
  input  logic [31:0] in_res,
  input  logic [31:0] in_store_data,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_wen,
  output logic [31:0] dcache_addr,
  output logic        dcache_ren,
  output logic        dcache_wen,
  output logic [31:0] dcache_wdata,
  output logic [3:0]  dcache_wmask,
  input  logic [31:0] dcache_rdata,
  input  logic        dcache_rdy,
  output logic        ctrl_mem_stall,
  output logic [31:0] wb_data_reg,
  output logic [4:0]  wb_rd_reg,
  output logic        wb_wen_reg,
  output logic        wb_valid_reg,
  output logic        mem_fault_reg
);

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic        is_mem, legal, aligned, access, bad;
  logic [1:0]  lane;
  logic [31:0] rd_shift, load_fmt;
  logic [15:0] rd_half;
  logic        timed_out;
  logic        req, mem_stall, commit, capture, to_fault;

  logic [31:0] res_data;
  logic        res_wen, res_fault;
  logic [31:0] hold_data;
  logic [4:0]  hold_rd;
  logic        hold_wen, hold_valid, hold_fault;

  assign lane   = in_res[1:0];
  assign is_mem = in_valid & (in_is_load | in_is_store);

  always_comb begin
    legal = 1'b0;
    if (in_is_load) begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
    case (in_funct3[1:0])
      2'b01:   aligned = ~in_res[0];
      2'b10:   aligned = (in_res[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign access = is_mem & legal & aligned;
  assign bad    = is_mem & ~(legal & aligned);

  assign rd_shift = dcache_rdata >> {lane, 3'b000};
  assign rd_half  = in_res[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];

  always_comb begin
    case (in_funct3)
      3'b000:  load_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_fmt = {24'h0, rd_shift[7:0]};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_fmt = {16'h0, rd_half};
      default: load_fmt = dcache_rdata;
    endcase
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b00: begin
        dcache_wdata = {4{in_store_data[7:0]}};
        dcache_wmask = 4'b0001 << lane;
      end
      2'b01: begin
        dcache_wdata = {2{in_store_data[15:0]}};
        dcache_wmask = 4'b0011 << {in_res[1], 1'b0};
      end
      default: begin
        dcache_wdata = in_store_data;
        dcache_wmask = 4'b1111;
      end
    endcase
  end

  assign dcache_addr = {in_res[31:2], 2'b00};
  assign timed_out   = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_W'(WAIT_TIMEOUT));

  // Result of the instruction currently presented; a timeout overrides it with a fault.
  always_comb begin
    res_data  = in_res;
    res_wen   = in_reg_wen;
    res_fault = 1'b0;
    if (bad || to_fault) begin
      res_data  = 32'h0;
      res_wen   = 1'b0;
      res_fault = 1'b1;
    end else if (access && in_is_load) begin
      res_data = load_fmt;
    end else if (access) begin
      res_wen = 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req          = 1'b0;
    mem_stall    = 1'b0;
    commit       = 1'b0;
    capture      = 1'b0;
    to_fault     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (dcache_rdy) begin
            if (ctrl_stall) begin
              capture   = 1'b1;
              state_nxt = S_HOLD;
            end else begin
              commit = 1'b1;
            end
          end else begin
            mem_stall    = 1'b1;
            state_nxt    = S_WAIT;
            wait_cnt_nxt = CNT_W'(1);
          end
        end else if (!ctrl_stall) begin
          commit = 1'b1;
        end
      end
      S_WAIT: begin
        if (dcache_rdy || timed_out) begin
          req      = dcache_rdy;
          to_fault = ~dcache_rdy;
          if (ctrl_stall) begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          req          = 1'b1;
          mem_stall    = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!ctrl_stall) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset gates the request combinationally so an in-flight access drops at once.
  assign dcache_ren     = ctrl_rst_n & req & in_is_load;
  assign dcache_wen     = ctrl_rst_n & req & in_is_store;
  assign ctrl_mem_stall = ctrl_rst_n & mem_stall;

  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      hold_data     <= 32'h0;
      hold_rd       <= 5'h0;
      hold_wen      <= 1'b0;
      hold_valid    <= 1'b0;
      hold_fault    <= 1'b0;
      wb_data_reg   <= 32'h0;
      wb_rd_reg     <= 5'h0;
      wb_wen_reg    <= 1'b0;
      wb_valid_reg  <= 1'b0;
      mem_fault_reg <= 1'b0;
    end else begin
      if (capture) begin
        hold_data  <= res_data;
        hold_rd    <= in_rd;
        hold_wen   <= res_wen;
        hold_valid <= in_valid;
        hold_fault <= res_fault;
      end
      if (commit) begin
        if (state == S_HOLD) begin
          wb_data_reg   <= hold_data;
          wb_rd_reg     <= hold_rd;
          wb_wen_reg    <= hold_wen;
          wb_valid_reg  <= hold_valid;
          mem_fault_reg <= hold_fault;
        end else begin
          wb_data_reg   <= res_data;
          wb_rd_reg     <= in_rd;
          wb_wen_reg    <= res_wen;
          wb_valid_reg  <= in_valid;
          mem_fault_reg <= res_fault;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load/store formatting, wait/hold/timeout and async reset.
module tb_mem_stage;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst_n;
  logic        ctrl_stall;
  logic        ext_stall;
  logic        in_valid;
  logic [31:0] in_res;
  logic [31:0] in_store_data;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_wen;
  logic [31:0] dcache_addr;
  logic        dcache_ren;
  logic        dcache_wen;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_wmask;
  logic [31:0] dcache_rdata;
  logic        dcache_rdy;
  logic        ctrl_mem_stall;
  logic [31:0] wb_data_reg;
  logic [4:0]  wb_rd_reg;
  logic        wb_wen_reg;
  logic        wb_valid_reg;
  logic        mem_fault_reg;

  int total = 0;
  int bad   = 0;
  int wen_txn = 0;
  int ren_hi  = 0;
  int base;
  int stall_cnt;

  always #5 ctrl_clk = ~ctrl_clk;

  assign ctrl_stall = ext_stall | ctrl_mem_stall;

  mem_stage #(.WAIT_TIMEOUT(4)) dut (
    .ctrl_clk      (ctrl_clk),
    .ctrl_rst_n    (ctrl_rst_n),
    .ctrl_stall    (ctrl_stall),
    .in_valid      (in_valid),
    .in_res        (in_res),
    .in_store_data (in_store_data),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_rd         (in_rd),
    .in_reg_wen    (in_reg_wen),
    .dcache_addr   (dcache_addr),
    .dcache_ren    (dcache_ren),
    .dcache_wen    (dcache_wen),
    .dcache_wdata  (dcache_wdata),
    .dcache_wmask  (dcache_wmask),
    .dcache_rdata  (dcache_rdata),
    .dcache_rdy    (dcache_rdy),
    .ctrl_mem_stall(ctrl_mem_stall),
    .wb_data_reg   (wb_data_reg),
    .wb_rd_reg     (wb_rd_reg),
    .wb_wen_reg    (wb_wen_reg),
    .wb_valid_reg  (wb_valid_reg),
    .mem_fault_reg (mem_fault_reg)
  );

  always @(posedge ctrl_clk) begin
    if (dcache_wen && dcache_rdy) wen_txn++;
    if (dcache_ren) ren_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    in_res        = 32'h0;
    in_store_data = 32'h0;
    in_is_load    = 1'b0;
    in_is_store   = 1'b0;
    in_funct3     = 3'b000;
    in_rd         = 5'd0;
    in_reg_wen    = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input logic wen);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_funct3     = f3;
    in_res        = res;
    in_store_data = sd;
    in_rd         = rd;
    in_reg_wen    = wen;
  endtask

  initial begin
    ctrl_rst_n   = 1'b0;
    ext_stall    = 1'b0;
    dcache_rdy   = 1'b0;
    dcache_rdata = 32'h0;
    idle_in();
    #2;
    check("rst_wb_data", wb_data_reg, 32'h0);
    check("rst_wb_valid", 32'(wb_valid_reg), 32'd0);
    check("rst_fault", 32'(mem_fault_reg), 32'd0);
    check("rst_ren", 32'(dcache_ren), 32'd0);
    check("rst_wen", 32'(dcache_wen), 32'd0);
    #10 ctrl_rst_n = 1'b1;
    step();

    // ALU pass-through
    drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    #2 check("alu_stall", 32'(ctrl_mem_stall), 32'd0);
    step();
    check("alu_data", wb_data_reg, 32'h0000_1234);
    check("alu_rd", 32'(wb_rd_reg), 32'd5);
    check("alu_wen", 32'(wb_wen_reg), 32'd1);
    check("alu_fault", 32'(mem_fault_reg), 32'd0);

    // Loads answered in the same cycle
    drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
    dcache_rdy   = 1'b1;
    dcache_rdata = 32'h80FF_0000;
    #2;
    check("lb_addr", dcache_addr, 32'h100);
    check("lb_ren", 32'(dcache_ren), 32'd1);
    check("lb_stall", 32'(ctrl_mem_stall), 32'd0);
    step();
    check("lb_data", wb_data_reg, 32'hFFFF_FF80);
    check("lb_rd", 32'(wb_rd_reg), 32'd7);
    in_funct3 = 3'b100;
    step();
    check("lbu_data", wb_data_reg, 32'h0000_0080);
    in_funct3 = 3'b001;
    in_res    = 32'h102;
    step();
    check("lh_data", wb_data_reg, 32'hFFFF_80FF);
    in_funct3 = 3'b101;
    step();
    check("lhu_data", wb_data_reg, 32'h0000_80FF);
    in_funct3 = 3'b010;
    in_res    = 32'h100;
    step();
    check("lw_data", wb_data_reg, 32'h80FF_0000);

    // SB answered in the same cycle
    drive(1'b0, 1'b1, 3'b000, 32'h401, 32'h1234_5678, 5'd3, 1'b1);
    #2;
    check("sb_wdata", dcache_wdata, 32'h7878_7878);
    check("sb_wmask", 32'(dcache_wmask), 32'h2);
    check("sb_wen", 32'(dcache_wen), 32'd1);
    check("sb_ren", 32'(dcache_ren), 32'd0);
    step();
    check("sb_wb_wen", 32'(wb_wen_reg), 32'd0);

    // SH with rdy after 3 cycles
    base = wen_txn;
    stall_cnt = 0;
    drive(1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd4, 1'b1);
    dcache_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 if (ctrl_mem_stall) stall_cnt++;
      step();
    end
    dcache_rdy = 1'b1;
    #2;
    check("sh_stall_end", 32'(ctrl_mem_stall), 32'd0);
    check("sh_wmask", 32'(dcache_wmask), 32'hC);
    check("sh_wdata", dcache_wdata, 32'hBEEF_BEEF);
    step();
    idle_in();
    dcache_rdy = 1'b0;
    check("sh_stall_cycles", 32'(stall_cnt), 32'd3);
    check("sh_wen_txn", 32'(wen_txn - base), 32'd1);
    check("sh_wb_wen", 32'(wb_wen_reg), 32'd0);
    check("sh_wb_valid", 32'(wb_valid_reg), 32'd1);

    // Misaligned LW and illegal store
    drive(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd6, 1'b1);
    #2;
    check("mis_ren", 32'(dcache_ren), 32'd0);
    check("mis_stall", 32'(ctrl_mem_stall), 32'd0);
    step();
    check("mis_fault", 32'(mem_fault_reg), 32'd1);
    check("mis_wb_wen", 32'(wb_wen_reg), 32'd0);
    drive(1'b0, 1'b1, 3'b100, 32'h300, 32'h55, 5'd0, 1'b0);
    #2 check("ill_wen", 32'(dcache_wen), 32'd0);
    step();
    check("ill_fault", 32'(mem_fault_reg), 32'd1);

    // LW completes under an external stall held 2 more cycles
    drive(1'b0, 1'b0, 3'b000, 32'h5555, 32'h0, 5'd1, 1'b1);
    step();
    check("pre_hold_fault", 32'(mem_fault_reg), 32'd0);
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd8, 1'b1);
    dcache_rdy   = 1'b1;
    dcache_rdata = 32'hCAFE_F00D;
    ext_stall    = 1'b1;
    #2 check("hold_ren_issue", 32'(dcache_ren), 32'd1);
    step();
    dcache_rdy   = 1'b0;
    dcache_rdata = 32'h0;
    base = ren_hi;
    for (int i = 0; i < 2; i++) begin
      #2 check("hold_no_rereq", 32'(dcache_ren), 32'd0);
      step();
      check("hold_wb_kept", wb_data_reg, 32'h0000_5555);
    end
    ext_stall = 1'b0;
    step();
    check("hold_wb_data", wb_data_reg, 32'hCAFE_F00D);
    check("hold_wb_rd", 32'(wb_rd_reg), 32'd8);
    check("hold_ren_edges", 32'(ren_hi - base), 32'd0);
    idle_in();

    // Timeout with WAIT_TIMEOUT=4
    drive(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd9, 1'b1);
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #2 if (ctrl_mem_stall) stall_cnt++;
      if (i == 4) check("to_ren_drop", 32'(dcache_ren), 32'd0);
      step();
    end
    check("to_stall_cycles", 32'(stall_cnt), 32'd4);
    check("to_fault", 32'(mem_fault_reg), 32'd1);
    check("to_wb_wen", 32'(wb_wen_reg), 32'd0);
    check("to_wb_rd", 32'(wb_rd_reg), 32'd9);

    // Same load re-enters WAIT; reset mid-WAIT
    step();
    #2 check("wait_ren", 32'(dcache_ren), 32'd1);
    ctrl_rst_n = 1'b0;
    #1;
    check("arst_ren", 32'(dcache_ren), 32'd0);
    check("arst_stall", 32'(ctrl_mem_stall), 32'd0);
    check("arst_wb_rd", 32'(wb_rd_reg), 32'd0);
    check("arst_wb_valid", 32'(wb_valid_reg), 32'd0);
    check("arst_fault", 32'(mem_fault_reg), 32'd0);
    idle_in();
    #3 ctrl_rst_n = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'hBEEF, 32'h0, 5'd2, 1'b1);
    step();
    check("post_rst_data", wb_data_reg, 32'h0000_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
